dut_port_arbiter: RTL
=====================

Name: dut_port_arbiter

Overview:
Shares the DUT's single write port and single read port among NUM_REQ independent requesters. Uses round-robin arbitration, with separate write and read arbiters. Drives the DUT's enable/ready method interface and never asserts an enable while the matching ready is low. Returns each read result, registered, to the requester that issued the read.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 3, DUT address width
DATA_W, 1, DUT data width

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
req_wr_valid  input  NUM_REQ  per-requester write request
req_wr_addr  input  NUM_REQ*ADDR_W  write address, requester i at slice [i*ADDR_W +: ADDR_W]
req_wr_data  input  NUM_REQ*DATA_W  write data, same packing
req_wr_ready  output  NUM_REQ  one-hot write accept
req_rd_valid  input  NUM_REQ  per-requester read request
req_rd_addr  input  NUM_REQ*ADDR_W  read address, same packing
req_rd_ready  output  NUM_REQ  one-hot read accept
rsp_rd_valid  output  NUM_REQ  one-hot read response pulse
rsp_rd_data  output  DATA_W  read response data
write_address  output  ADDR_W  to DUT
write_data  output  DATA_W  to DUT
write_en  output  1  to DUT
write_rdy  input  1  from DUT
read_address  output  ADDR_W  to DUT
read_en  output  1  to DUT
read_data  input  DATA_W  from DUT, valid in the cycle read_en is high
read_rdy  input  1  from DUT

Behaviour:
- Reset (RST_N low, asynchronous): wr_ptr=0, rd_ptr=0, rsp_rd_valid=0, rsp_rd_data=0. write_en, read_en, req_wr_ready and req_rd_ready evaluate to 0 because grants are suppressed while in reset.
- Write grant (combinational): when write_rdy=1, grant the first requester i with req_wr_valid[i]=1, searching from wr_ptr upward and wrapping modulo NUM_REQ.
- Write port outputs:
  - write_en = |grant.
  - write_address and write_data are muxed from the granted requester's slice.
  - When there is no grant, write_address and write_data are 0.
- req_wr_ready = write grant vector, which is one-hot or zero. A transfer completes in any cycle with valid&ready.
- Requester rules:
  - Hold valid and payload stable until ready.
  - valid must not depend on ready.
- When write_rdy=0: no grant, write_en=0, wr_ptr unchanged.
- On a write grant to i: wr_ptr <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Reads use an identical arbiter (rd_ptr, read_rdy, req_rd_valid, req_rd_ready, read_address, read_en). It is independent of the write arbiter.
- Read response (latency 1): in the cycle after a read grant to i, rsp_rd_valid = one-hot(i) for exactly 1 cycle. rsp_rd_data holds the read_data sampled on the grant edge. rsp_rd_data holds its value when no response is issued.
- Back-to-back reads: a new grant can occur every cycle, and the response pipeline carries one response per cycle with no stall. Responses have no back-pressure; requesters must always accept them.
- Simultaneous write and read in one cycle, including to the same address: both are issued. Ordering semantics are the DUT's.
- Single requester: gets every cycle in which the DUT is ready.
- Reset mid-operation: any pending response is dropped, with no rsp_rd_valid pulse. Arbitration restarts at requester 0.

Optional Feature:
Macro PORT_ARB_STATS_EN.
- Defined: adds outputs stat_wr_grants and stat_rd_grants, each NUM_REQ*16 bits. These are per-requester 16-bit counters that increment on each grant and saturate at 16'hFFFF. They reset to 0 on RST_N low.
- Also adds input stat_clr (1 bit), which synchronously zeroes all counters. If stat_clr coincides with a grant, clear wins.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dut_arb_pkg holds:
  - ADDR_W=3, DATA_W=1 and STAT_W=16 constants;
  - a helper function that computes the round-robin next-pointer.
- Sub-module rr_arbiter (parameter N): inputs valid vector, enable (the DUT ready) and CLK/RST_N; outputs a one-hot grant; owns its pointer. Instantiated twice, once for writes and once for reads.

Test Plan:
- Reset: hold RST_N=0 with all valids=1 and both DUT readies=1 -> write_en=0, read_en=0, rsp_rd_valid=0, all ready outputs 0. Release -> the first grant goes to requester 0.
- Single writer: req_wr_valid=2'b10, addr 4, data 1, write_rdy=1 -> same cycle: write_en=1, write_address=4, write_data=1, req_wr_ready=2'b10.
- Contention: both writers hold valid for 4 cycles, write_rdy=1 -> grants in order 0,1,0,1, with exactly one write_en per cycle.
- Back-pressure: req0 write valid, write_rdy=0 for 3 cycles -> write_en=0 and req_wr_ready=0 throughout. write_rdy=1 on cycle 4 -> grant to req0 in that cycle.
- Read return: req1 reads addr 3 with read_rdy=1 and read_data=1 -> next cycle rsp_rd_valid=2'b10, rsp_rd_data=1. Back-to-back reads from req0 then req1 -> responses on consecutive cycles.
- Stats (PORT_ARB_STATS_EN): 3 write grants to req0 -> stat_wr_grants[15:0]=3. Pulse stat_clr -> 0. Force the counter to 16'hFFFF, then grant -> it stays 16'hFFFF.

Source files
------------

// File: rtl/dut_arb_pkg.sv
// Shared constants and round-robin pointer helpers for the DUT port arbiter.
package dut_arb_pkg;

   localparam int ADDR_W  = 3;
   localparam int DATA_W  = 1;
   localparam int STAT_W  = 16;
   localparam int MAX_REQ = 8;

   // Wide enough for the largest supported requester count.
   typedef logic [2:0] ptr_t;

   function automatic ptr_t rr_wrap(input ptr_t base, input int off, input int n);
      int s;
      s = int'(base) + off;
      if (s >= n) s = s - n;
      return ptr_t'(s);
   endfunction

   function automatic ptr_t rr_next_ptr(input ptr_t idx, input int n);
      return rr_wrap(idx, 1, n);
   endfunction

endpackage

// File: rtl/dut_port_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward, pointer
// advances past the winner. Grants are forced off while reset is asserted.
module rr_arbiter
   import dut_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         en,
   input  logic [N-1:0] valid,
   output logic [N-1:0] gnt
);

   ptr_t ptr_q, ptr_d;
   ptr_t idx;
   logic found;

   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = rr_wrap(ptr_q, k, N);
         for (int i = 0; i < N; i++) begin
            if (!found && en && RST_N && valid[i] && (idx == ptr_t'(i))) begin
               gnt[i] = 1'b1;
               ptr_d  = rr_next_ptr(idx, N);
               found  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/dut_port_arbiter.sv
// Shares one DUT write port and one read port among NUM_REQ requesters with
// independent round-robin arbiters. Optional grant counters: PORT_ARB_STATS_EN.
module dut_port_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = dut_arb_pkg::ADDR_W,
   parameter int DATA_W  = dut_arb_pkg::DATA_W
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [NUM_REQ-1:0]          req_wr_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_wr_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wr_data,
   output logic [NUM_REQ-1:0]          req_wr_ready,
   input  logic [NUM_REQ-1:0]          req_rd_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_rd_addr,
   output logic [NUM_REQ-1:0]          req_rd_ready,
   output logic [NUM_REQ-1:0]          rsp_rd_valid,
   output logic [DATA_W-1:0]           rsp_rd_data,
   output logic [ADDR_W-1:0]           write_address,
   output logic [DATA_W-1:0]           write_data,
   output logic                        write_en,
   input  logic                        write_rdy,
   output logic [ADDR_W-1:0]           read_address,
   output logic                        read_en,
   input  logic [DATA_W-1:0]           read_data,
`ifdef PORT_ARB_STATS_EN
   input  logic                                    stat_clr,
   output logic [NUM_REQ*dut_arb_pkg::STAT_W-1:0]  stat_wr_grants,
   output logic [NUM_REQ*dut_arb_pkg::STAT_W-1:0]  stat_rd_grants,
`endif
   input  logic                        read_rdy
);

   logic [NUM_REQ-1:0] wgnt, rgnt;
   logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
   logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

   rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (write_rdy),
      .valid (req_wr_valid),
      .gnt   (wgnt)
   );

   rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (read_rdy),
      .valid (req_rd_valid),
      .gnt   (rgnt)
   );

   assign req_wr_ready = wgnt;
   assign req_rd_ready = rgnt;
   assign write_en     = |wgnt;
   assign read_en      = |rgnt;

   // Grants are one-hot, so OR-ing the selected slices is a plain mux.
   always_comb begin
      write_address = '0;
      write_data    = '0;
      read_address  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wgnt[i]) begin
            write_address = write_address | req_wr_addr[i*ADDR_W +: ADDR_W];
            write_data    = write_data    | req_wr_data[i*DATA_W +: DATA_W];
         end
         if (rgnt[i]) read_address = read_address | req_rd_addr[i*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      rsp_vld_d  = rgnt;
      rsp_data_d = read_en ? read_data : rsp_data_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign rsp_rd_valid = rsp_vld_q;
   assign rsp_rd_data  = rsp_data_q;

`ifdef PORT_ARB_STATS_EN
   localparam int SW = dut_arb_pkg::STAT_W;

   logic [NUM_REQ-1:0][SW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

   // Saturating per-requester grant counters; clear beats a same-cycle grant.
   always_comb begin
      wcnt_d = wcnt_q;
      rcnt_d = rcnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stat_clr) begin
            wcnt_d[i] = '0;
            rcnt_d[i] = '0;
         end else begin
            if (wgnt[i] && (wcnt_q[i] != '1)) wcnt_d[i] = wcnt_q[i] + SW'(1);
            if (rgnt[i] && (rcnt_q[i] != '1)) rcnt_d[i] = rcnt_q[i] + SW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wcnt_q <= '0;
         rcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         rcnt_q <= rcnt_d;
      end
   end

   assign stat_wr_grants = wcnt_q;
   assign stat_rd_grants = rcnt_q;
`endif

endmodule
